pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage NPC core (F/D/E/M/W). It generates the stage-register write enables (`valid_D`, `valid_E`, `valid_M`) and flush strobes (`flash_D`, `flash_E`) used by the datapath and instruction-trace registers. It tracks per-stage occupancy and resolves load-use hazards, taken-branch redirects and multi-cycle LSU accesses. It also produces the per-instruction retire pulse, a retire counter and the `ebreak` halt.

---
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: F/D/E/M/W sequencing, hazard resolution, retire count, ebreak halt.
// Ports: clk, rst (async, active-low); fetch handshake (ifu_valid/ifu_ready);
//   D/E hazard inputs (rs*_D, use_rs*_D, rd_E, is_load_E, regwrite_E,
//   branch_taken_E); M/W inputs (lsu_req_M, lsu_done, ebreak_W);
//   stage enables valid_D/E/M, flushes flash_D/E, redirect, occ_D..W,
//   retire_W, retire_cnt, halted.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_valid,
    output logic             ifu_ready,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       rd_E,
    input  logic             is_load_E,
    input  logic             regwrite_E,
    input  logic             branch_taken_E,
    input  logic             lsu_req_M,
    input  logic             lsu_done,
    input  logic             ebreak_W,
    output logic             valid_D,
    output logic             valid_E,
    output logic             valid_M,
    output logic             flash_D,
    output logic             flash_E,
    output logic             redirect,
    output logic             occ_D,
    output logic             occ_E,
    output logic             occ_M,
    output logic             occ_W,
    output logic             retire_W,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted
);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_occ_D;
    logic             r_occ_E;
    logic             r_occ_M;
    logic             r_occ_W;
    logic [CNT_W-1:0] r_cnt;

    logic w_halt;
    logic w_mem_stall;
    logic w_br;
    logic w_rs_hit;
    logic w_load_use;
    logic w_adv;
    logic w_ready;
    logic w_flash_D;
    logic w_flash_E;
    logic w_retire;

    always_comb begin
        w_halt      = (r_state == S_HALT);
        w_mem_stall = ~w_halt & r_occ_M & lsu_req_M & ~lsu_done;
        w_br        = ~w_halt & r_occ_E & branch_taken_E;
        w_rs_hit    = (use_rs1_D & (rs1_D == rd_E))
                    | (use_rs2_D & (rs2_D == rd_E));
        // A taken branch flushes D anyway, so it wins over a load-use hold.
        w_load_use  = ~w_halt & ~w_br & r_occ_D & r_occ_E & is_load_E
                    & regwrite_E & (rd_E != 5'd0) & w_rs_hit;
        w_adv       = ~w_halt & ~w_mem_stall;
        w_ready     = w_adv & ~w_load_use;
        w_flash_E   = w_adv & (w_load_use | w_br);
        w_flash_D   = w_adv & w_br;
        w_retire    = r_occ_W & ~w_halt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN, S_MEM_WAIT: begin
                if (r_occ_W & ebreak_W) begin
                    w_state_nxt = S_HALT;
                end else if (w_mem_stall) begin
                    w_state_nxt = S_MEM_WAIT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush dominates enable; everything freezes once halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ_D <= 1'b0;
            r_occ_E <= 1'b0;
            r_occ_M <= 1'b0;
            r_occ_W <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_halt) begin
            r_occ_W <= r_occ_M & ~w_mem_stall;
            r_occ_M <= w_mem_stall ? r_occ_M : r_occ_E;
            r_occ_E <= w_flash_E ? 1'b0
                     : (w_ready ? r_occ_D : r_occ_E);
            r_occ_D <= w_flash_D ? 1'b0
                     : (w_ready ? ifu_valid : r_occ_D);
            if (w_retire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ifu_ready  = w_ready;
    assign valid_D    = w_ready;
    assign valid_E    = w_adv;
    assign valid_M    = w_adv;
    assign flash_D    = w_flash_D;
    assign flash_E    = w_flash_E;
    assign redirect   = w_flash_D;
    assign occ_D      = r_occ_D;
    assign occ_E      = r_occ_E;
    assign occ_M      = r_occ_M;
    assign occ_W      = r_occ_W;
    assign retire_W   = w_retire;
    assign retire_cnt = r_cnt;
    assign halted     = w_halt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random stimulus against an event-level pipeline model.
// Directed straight-line, async reset and ebreak halt scenarios included.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [4:0]  rs1_D;
    logic [4:0]  rs2_D;
    logic        use_rs1_D;
    logic        use_rs2_D;
    logic [4:0]  rd_E;
    logic        is_load_E;
    logic        regwrite_E;
    logic        branch_taken_E;
    logic        lsu_req_M;
    logic        lsu_done;
    logic        ebreak_W;
    logic        valid_D;
    logic        valid_E;
    logic        valid_M;
    logic        flash_D;
    logic        flash_E;
    logic        redirect;
    logic        occ_D;
    logic        occ_E;
    logic        occ_M;
    logic        occ_W;
    logic        retire_W;
    logic [31:0] retire_cnt;
    logic        halted;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_valid      (ifu_valid),
        .ifu_ready      (ifu_ready),
        .rs1_D          (rs1_D),
        .rs2_D          (rs2_D),
        .use_rs1_D      (use_rs1_D),
        .use_rs2_D      (use_rs2_D),
        .rd_E           (rd_E),
        .is_load_E      (is_load_E),
        .regwrite_E     (regwrite_E),
        .branch_taken_E (branch_taken_E),
        .lsu_req_M      (lsu_req_M),
        .lsu_done       (lsu_done),
        .ebreak_W       (ebreak_W),
        .valid_D        (valid_D),
        .valid_E        (valid_E),
        .valid_M        (valid_M),
        .flash_D        (flash_D),
        .flash_E        (flash_E),
        .redirect       (redirect),
        .occ_D          (occ_D),
        .occ_E          (occ_E),
        .occ_M          (occ_M),
        .occ_W          (occ_W),
        .retire_W       (retire_W),
        .retire_cnt     (retire_cnt),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Model: which stages hold an instruction (0=D 1=E 2=M 3=W).
    bit          mv [4];
    bit          m_halt;
    logic [31:0] m_cnt;
    bit          last_ret;

    localparam int EV_HALT  = 0;
    localparam int EV_STALL = 1;
    localparam int EV_BR    = 2;
    localparam int EV_LU    = 3;
    localparam int EV_FLOW  = 4;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Classify what the pipe does this cycle.
    function automatic int model_event();
        bit hit;
        if (m_halt) return EV_HALT;
        if (mv[2] && lsu_req_M && !lsu_done) return EV_STALL;
        if (mv[1] && branch_taken_E) return EV_BR;
        hit = (use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E);
        if (mv[0] && mv[1] && is_load_E && regwrite_E && rd_E != 5'd0 && hit)
            return EV_LU;
        return EV_FLOW;
    endfunction

    task automatic quiet_in();
        ifu_valid      = 1'b0;
        rs1_D          = 5'd0;
        rs2_D          = 5'd0;
        use_rs1_D      = 1'b0;
        use_rs2_D      = 1'b0;
        rd_E           = 5'd0;
        is_load_E      = 1'b0;
        regwrite_E     = 1'b0;
        branch_taken_E = 1'b0;
        lsu_req_M      = 1'b0;
        lsu_done       = 1'b0;
        ebreak_W       = 1'b0;
    endtask

    task automatic rand_in();
        ifu_valid      = ($urandom_range(0, 9) < 8);
        rs1_D          = 5'($urandom_range(0, 3));
        rs2_D          = 5'($urandom_range(0, 3));
        use_rs1_D      = 1'($urandom);
        use_rs2_D      = 1'($urandom);
        rd_E           = 5'($urandom_range(0, 3));
        is_load_E      = ($urandom_range(0, 9) < 4);
        regwrite_E     = ($urandom_range(0, 9) < 8);
        branch_taken_E = ($urandom_range(0, 99) < 15);
        lsu_req_M      = ($urandom_range(0, 9) < 4);
        lsu_done       = 1'($urandom);
        ebreak_W       = ($urandom_range(0, 39) == 0);
    endtask

    // Entered and left at a falling edge with inputs already applied.
    task automatic cycle();
        int         ev;
        logic [6:0] en;
        bit         hn;
        #1;
        ev = model_event();
        case (ev)
            EV_BR:   en = 7'b1111111;
            EV_LU:   en = 7'b0011010;
            EV_FLOW: en = 7'b1111000;
            default: en = 7'b0000000;
        endcase
        chk("enables", {25'd0, ifu_ready, valid_D, valid_E, valid_M,
                        flash_D, flash_E, redirect}, {25'd0, en});
        chk("occ", {28'd0, occ_W, occ_M, occ_E, occ_D},
            {28'd0, mv[3], mv[2], mv[1], mv[0]});
        chk("retire", {31'd0, retire_W}, {31'd0, mv[3] && !m_halt});
        chk("cnt", retire_cnt, m_cnt);
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        last_ret = retire_W;
        @(posedge clk);
        hn = m_halt;
        if (!m_halt && mv[3]) begin
            m_cnt = m_cnt + 1;
            if (ebreak_W) hn = 1'b1;
        end
        case (ev)
            EV_STALL: mv[3] = 1'b0;
            EV_BR: begin
                mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = 1'b0; mv[0] = 1'b0;
            end
            EV_LU: begin
                mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = 1'b0;
            end
            EV_FLOW: begin
                mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0];
                mv[0] = ifu_valid;
            end
            default: ;
        endcase
        m_halt = hn;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        m_halt = 1'b0;
        m_cnt  = '0;
    endtask

    // Asynchronous reset in the middle of the low phase.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_occ", {28'd0, occ_W, occ_M, occ_E, occ_D}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_halt", {31'd0, halted}, 32'd0);
        chk("rst_ret", {31'd0, retire_W}, 32'd0);
        chk("rst_en", {25'd0, ifu_ready, valid_D, valid_E, valid_M,
                       flash_D, flash_E, redirect}, 32'h78);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int first_ret;
        quiet_in();
        model_reset();
        last_ret = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Straight line: 5 fetches, first retire 4 cycles later.
        first_ret = -1;
        for (int k = 0; k < 10; k++) begin
            quiet_in();
            ifu_valid = (k < 5);
            cycle();
            if (last_ret && first_ret < 0) first_ret = k;
        end
        chk("sl_lat", first_ret, 32'd4);
        #1 chk("sl_cnt", retire_cnt, 32'd5);

        do_reset();

        // Eight instructions, the last is ebreak.
        for (int k = 0; k < 14; k++) begin
            quiet_in();
            ifu_valid = (k < 8);
            ebreak_W  = (k == 11);
            cycle();
        end
        #1;
        chk("h_cnt", retire_cnt, 32'd8);
        chk("h_halt", {31'd0, halted}, 32'd1);
        chk("h_ready", {31'd0, ifu_ready}, 32'd0);

        do_reset();

        for (int i = 0; i < 4000; i++) begin
            if ((m_halt && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 299) == 0) begin
                do_reset();
            end
            rand_in();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
